// File: rtl/cas_pkg.sv
// Shared types, default MSX tape timing constants and header-length helper
// for the cassette FSK transmitter.
package cas_pkg;

   typedef enum logic [1:0] {
      CAS_DATA = 2'b00,
      CAS_SHDR = 2'b01,
      CAS_LHDR = 2'b10,
      CAS_SIL  = 2'b11
   } cas_cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_HDR  = 2'b01,
      ST_BIT  = 2'b10,
      ST_SIL  = 2'b11
   } cas_state_e;

   localparam int unsigned CAS_HALF_2400 = 32'd746;
   localparam int unsigned CAS_LONG_HDR  = 32'd16000;
   localparam int unsigned CAS_SHORT_HDR = 32'd4000;
   localparam int unsigned CAS_FRAME_LEN = 32'd11;
   localparam int unsigned CAS_HALF_W    = 32'd11;

   // Header half-periods; the fast rate doubles the cycle count to keep the duration.
   function automatic int unsigned cas_hdr_halves(input int unsigned cycles, input logic fast);
      if (fast) begin
         return 32'd4 * cycles;
      end else begin
         return 32'd2 * cycles;
      end
   endfunction

endpackage

// File: rtl/cas_fsk_tx_halfper_gen.sv
// Half-period timer for the FSK transmitter: counts ce ticks while the motor
// runs and flags the tick that ends the current half-period.
module cas_halfper_gen
   import cas_pkg::*;
(
   input  logic                  clk21m,
   input  logic                  reset_n,
   input  logic                  ce,
   input  logic                  motor,
   input  logic                  restart,
   input  logic [CAS_HALF_W-1:0] half_len,
   output logic                  wrap
);

   logic [CAS_HALF_W-1:0] cnt_r;
   logic                  at_end_s;

   assign at_end_s = (cnt_r == (half_len - 11'd1));
   // A stopped motor masks the tick, so a coincident final tick is dropped.
   assign wrap     = ce & motor & ~restart & at_end_s;

   // Tick counter, held at zero between commands.
   always_ff @(posedge clk21m) begin
      if (!reset_n) begin
         cnt_r <= 11'd0;
      end else if (restart) begin
         cnt_r <= 11'd0;
      end else if (ce && motor) begin
         if (at_end_s) begin
            cnt_r <= 11'd0;
         end else begin
            cnt_r <= cnt_r + 11'd1;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/cas_fsk_tx.sv
// Cassette FSK transmitter (MSX 1200 baud): headers, framed bytes and silence.
// Optional 2400 baud mode with a baud_sel input when CAS_BAUD2400_EN is defined.
module cas_fsk_tx
   import cas_pkg::*;
#(
   parameter int unsigned HALF_2400 = CAS_HALF_2400,
   parameter int unsigned LONG_HDR  = CAS_LONG_HDR,
   parameter int unsigned SHORT_HDR = CAS_SHORT_HDR
)(
   input  logic       clk21m,
   input  logic       reset_n,
   input  logic       ce_3m58_p,
   input  logic       motor,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_type,
   input  logic [7:0] cmd_data,
`ifdef CAS_BAUD2400_EN
   input  logic       baud_sel,
`endif
   output logic       cas_audio_out,
   output logic       busy,
   output logic       done
);

`ifdef CAS_BAUD2400_EN
   localparam int unsigned HDR_W = 32'd16;
`else
   localparam int unsigned HDR_W = 32'd15;
`endif
   localparam logic [CAS_HALF_W-1:0] LEN_SHORT = 11'(HALF_2400);
   localparam logic [CAS_HALF_W-1:0] LEN_LONG  = 11'(32'd2 * HALF_2400);
   localparam logic [3:0]            LAST_BIT  = 4'(CAS_FRAME_LEN - 32'd1);

   cas_state_e            state_r, state_d;
   logic                  level_r, level_d;
   logic [10:0]           frame_r, frame_d;
   logic [3:0]            bit_r, bit_d;
   logic [1:0]            half_r, half_d;
   logic [HDR_W-1:0]      hcnt_r, hcnt_d;
   logic [HDR_W-1:0]      hlast_r, hlast_d;
   logic [7:0]            unit_r, unit_d;
   logic [7:0]            ulast_r, ulast_d;
   logic [CAS_HALF_W-1:0] base_len_s, half_len_s;
   logic [1:0]            last_half_s;
   logic                  fast_s;
   logic                  restart_s;
   logic                  wrap_s;

`ifdef CAS_BAUD2400_EN
   logic baud_r;

   assign fast_s     = baud_sel;
   assign half_len_s = baud_r ? {1'b0, base_len_s[CAS_HALF_W-1:1]} : base_len_s;

   // Rate selection captured with the command.
   always_ff @(posedge clk21m) begin
      if (!reset_n) begin
         baud_r <= 1'b0;
      end else if (cmd_valid && (state_r == ST_IDLE)) begin
         baud_r <= baud_sel;
      end else begin
         baud_r <= baud_r;
      end
   end
`else
   assign fast_s     = 1'b0;
   assign half_len_s = base_len_s;
`endif

   assign restart_s   = (state_r == ST_IDLE);
   assign last_half_s = frame_r[0] ? 2'd3 : 2'd1;

   // Zero bits use the long half-period; everything else uses the short one.
   always_comb begin
      base_len_s = LEN_SHORT;
      if ((state_r == ST_BIT) && !frame_r[0]) begin
         base_len_s = LEN_LONG;
      end else begin
         base_len_s = LEN_SHORT;
      end
   end

   cas_halfper_gen u_halfper (
      .clk21m   (clk21m),
      .reset_n  (reset_n),
      .ce       (ce_3m58_p),
      .motor    (motor),
      .restart  (restart_s),
      .half_len (half_len_s),
      .wrap     (wrap_s)
   );

   // Next-state, frame shifting and unit counting.
   always_comb begin
      state_d = state_r;
      level_d = level_r;
      frame_d = frame_r;
      bit_d   = bit_r;
      half_d  = half_r;
      hcnt_d  = hcnt_r;
      hlast_d = hlast_r;
      unit_d  = unit_r;
      ulast_d = ulast_r;
      case (state_r)
         ST_IDLE: begin
            level_d = 1'b0;
            if (cmd_valid) begin
               bit_d  = 4'd0;
               half_d = 2'd0;
               hcnt_d = HDR_W'(32'd0);
               unit_d = 8'd0;
               case (cas_cmd_e'(cmd_type))
                  CAS_DATA: begin
                     state_d = ST_BIT;
                     level_d = 1'b1;
                     frame_d = {2'b11, cmd_data, 1'b0};
                  end
                  CAS_SHDR: begin
                     state_d = ST_HDR;
                     level_d = 1'b1;
                     hlast_d = HDR_W'(cas_hdr_halves(SHORT_HDR, fast_s) - 32'd1);
                  end
                  CAS_LHDR: begin
                     state_d = ST_HDR;
                     level_d = 1'b1;
                     hlast_d = HDR_W'(cas_hdr_halves(LONG_HDR, fast_s) - 32'd1);
                  end
                  CAS_SIL: begin
                     state_d = ST_SIL;
                     ulast_d = cmd_data;
                  end
                  default: begin
                     state_d = ST_IDLE;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HDR: begin
            if (wrap_s) begin
               if (hcnt_r == hlast_r) begin
                  state_d = ST_IDLE;
                  level_d = 1'b0;
               end else begin
                  hcnt_d  = hcnt_r + HDR_W'(32'd1);
                  level_d = ~level_r;
               end
            end else begin
               state_d = ST_HDR;
            end
         end
         ST_BIT: begin
            if (wrap_s) begin
               if (half_r == last_half_s) begin
                  if (bit_r == LAST_BIT) begin
                     state_d = ST_IDLE;
                     level_d = 1'b0;
                  end else begin
                     bit_d   = bit_r + 4'd1;
                     frame_d = {1'b0, frame_r[10:1]};
                     half_d  = 2'd0;
                     level_d = 1'b1;
                  end
               end else begin
                  half_d  = half_r + 2'd1;
                  level_d = ~level_r;
               end
            end else begin
               state_d = ST_BIT;
            end
         end
         ST_SIL: begin
            level_d = 1'b0;
            if (wrap_s) begin
               if (half_r == 2'd3) begin
                  half_d = 2'd0;
                  if (unit_r == ulast_r) begin
                     state_d = ST_IDLE;
                  end else begin
                     unit_d = unit_r + 8'd1;
                  end
               end else begin
                  half_d = half_r + 2'd1;
               end
            end else begin
               state_d = ST_SIL;
            end
         end
         default: begin
            state_d = ST_IDLE;
            level_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; motor off forces the audio low without losing the level.
   always_ff @(posedge clk21m) begin
      if (!reset_n) begin
         state_r       <= ST_IDLE;
         level_r       <= 1'b0;
         frame_r       <= 11'd0;
         bit_r         <= 4'd0;
         half_r        <= 2'd0;
         hcnt_r        <= HDR_W'(32'd0);
         hlast_r       <= HDR_W'(32'd0);
         unit_r        <= 8'd0;
         ulast_r       <= 8'd0;
         cas_audio_out <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         cmd_ready     <= 1'b1;
      end else begin
         state_r       <= state_d;
         level_r       <= level_d;
         frame_r       <= frame_d;
         bit_r         <= bit_d;
         half_r        <= half_d;
         hcnt_r        <= hcnt_d;
         hlast_r       <= hlast_d;
         unit_r        <= unit_d;
         ulast_r       <= ulast_d;
         cas_audio_out <= motor & level_d;
         busy          <= (state_d != ST_IDLE);
         done          <= (state_r != ST_IDLE) && (state_d == ST_IDLE);
         cmd_ready     <= (state_d == ST_IDLE);
      end
   end

endmodule

// File: tb/tb_cas_fsk_tx.sv
// Scoreboard bench for cas_fsk_tx: commands push expected (level, ticks, end)
// segments; a monitor rebuilds segments from the audio output and compares.
module tb_cas_fsk_tx;

   localparam int unsigned H  = 4;
   localparam int unsigned SH = 3;
   localparam int unsigned LH = 5;
   localparam int unsigned LIMIT = 20000;

   logic       clk21m    = 1'b0;
   logic       reset_n   = 1'b0;
   logic       ce_3m58_p = 1'b0;
   logic       motor     = 1'b1;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_type  = 2'b00;
   logic [7:0] cmd_data  = 8'h00;
   logic       cas_audio_out;
   logic       busy;
   logic       done;
`ifdef CAS_BAUD2400_EN
   logic       baud_sel  = 1'b0;
`endif

   typedef struct {
      logic        level;
      int unsigned ticks;
      logic        last;
   } seg_t;

   seg_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk21m = ~clk21m;

   cas_fsk_tx #(.HALF_2400(H), .LONG_HDR(LH), .SHORT_HDR(SH)) dut (
      .clk21m        (clk21m),
      .reset_n       (reset_n),
      .ce_3m58_p     (ce_3m58_p),
      .motor         (motor),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_type      (cmd_type),
      .cmd_data      (cmd_data),
`ifdef CAS_BAUD2400_EN
      .baud_sel      (baud_sel),
`endif
      .cas_audio_out (cas_audio_out),
      .busy          (busy),
      .done          (done)
   );

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_seg(input logic lv, input int unsigned tk, input logic lst);
      seg_t s;
      s.level = lv;
      s.ticks = tk;
      s.last  = lst;
      exp_q.push_back(s);
   endtask

   // Reference: waveform of a command as alternating level segments measured in ce ticks.
   task automatic model(input logic [1:0] t, input logic [7:0] d);
      logic [10:0] frame;
      int unsigned n;
      case (t)
         2'b00: begin
            frame = {2'b11, d, 1'b0};
            for (int i = 0; i < 11; i++) begin
               if (frame[i]) begin
                  push_seg(1'b1, H, 1'b0);
                  push_seg(1'b0, H, 1'b0);
                  push_seg(1'b1, H, 1'b0);
                  push_seg(1'b0, H, i == 10);
               end else begin
                  push_seg(1'b1, 2 * H, 1'b0);
                  push_seg(1'b0, 2 * H, i == 10);
               end
            end
         end
         2'b01, 2'b10: begin
            n = (t == 2'b01) ? SH : LH;
            for (int c = 0; c < int'(n); c++) begin
               push_seg(1'b1, H, 1'b0);
               push_seg(1'b0, H, c == int'(n) - 1);
            end
         end
         default: push_seg(1'b0, (32'(d) + 32'd1) * 32'd4 * H, 1'b1);
      endcase
   endtask

   // Random ce pattern, driven away from the active edge.
   initial begin
      forever begin
         @(negedge clk21m);
         ce_3m58_p = ($urandom_range(0, 2) != 0);
      end
   end

   logic        true_level = 1'b0;
   logic        in_cmd     = 1'b0;
   logic        seg_level  = 1'b0;
   int unsigned seg_ticks  = 0;

   task automatic close_seg(input logic lst);
      seg_t e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL segment: got level=%0b ticks=%0d end=%0b, expected none", seg_level, seg_ticks, lst);
      end else begin
         e = exp_q.pop_front();
         if (seg_level !== e.level || seg_ticks != e.ticks || lst !== e.last) begin
            miscompares++;
            $display("FAIL segment: got level=%0b ticks=%0d end=%0b, expected level=%0b ticks=%0d end=%0b",
                     seg_level, seg_ticks, lst, e.level, e.ticks, e.last);
         end
      end
   endtask

   // Monitor: samples just after each edge using the ce/motor the DUT saw at that edge.
   initial begin
      forever begin
         @(posedge clk21m);
         #1;
         if (!reset_n) begin
            in_cmd     = 1'b0;
            true_level = 1'b0;
            exp_q.delete();
         end else begin
            if (motor) true_level = cas_audio_out;
            if (in_cmd && motor && ce_3m58_p) seg_ticks++;
            if (in_cmd) begin
               if (done) begin
                  close_seg(1'b1);
                  in_cmd = 1'b0;
               end else if (!busy) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL busy_dropped: got busy=0 without done, expected busy=1");
                  in_cmd = 1'b0;
               end else if (true_level != seg_level) begin
                  close_seg(1'b0);
                  seg_level = true_level;
                  seg_ticks = 0;
               end
            end else if (done) begin
               vectors++;
               miscompares++;
               $display("FAIL spurious_done: got done=1 while idle, expected 0");
            end
            if (!in_cmd && busy) begin
               in_cmd    = 1'b1;
               seg_level = true_level;
               seg_ticks = 0;
            end
         end
      end
   end

   task automatic send(input logic [1:0] t, input logic [7:0] d);
      int n;
      n = 0;
      cmd_type  = t;
      cmd_data  = d;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < int'(LIMIT)) begin
         @(negedge clk21m);
         n++;
      end
      if (n >= int'(LIMIT)) begin
         check("accept_timeout", 0, 1);
      end else begin
         if (n > 0) check("accept_after_done", int'(done), 1);
         model(t, d);
         @(negedge clk21m);
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk21m);
      while (busy && n < int'(LIMIT)) begin
         @(negedge clk21m);
         n++;
      end
      check("idle_reached", int'(busy), 0);
   endtask

   initial begin
      logic [1:0] t;
      logic [7:0] d;
      repeat (3) @(negedge clk21m);
      check("rst_audio", int'(cas_audio_out), 0);
      check("rst_ready", int'(cmd_ready), 1);
      check("rst_busy",  int'(busy), 0);
      check("rst_done",  int'(done), 0);
      reset_n = 1'b1;
      @(negedge clk21m);

      send(2'b00, 8'hA5);
      check("busy_after_accept", int'(busy), 1);
      check("audio_first_high", int'(cas_audio_out), 1);
      wait_idle();
      check("ready_after_byte", int'(cmd_ready), 1);
      send(2'b01, 8'h00);
      wait_idle();
      check("audio_idle_low", int'(cas_audio_out), 0);
      send(2'b11, 8'd2);
      wait_idle();

      // Motor pause in the middle of a byte.
      send(2'b00, 8'h3C);
      repeat (40) @(negedge clk21m);
      motor = 1'b0;
      repeat (3) @(negedge clk21m);
      check("pause_audio_low", int'(cas_audio_out), 0);
      repeat (97) @(negedge clk21m);
      check("pause_busy_held", int'(busy), 1);
      motor = 1'b1;
      wait_idle();

      // Second command held while the first is still running.
      send(2'b00, 8'h5A);
      send(2'b10, 8'h00);
      check("ready_low_when_busy", int'(cmd_ready), 0);
      wait_idle();

      // Reset in the middle of a byte.
      send(2'b00, 8'hFF);
      repeat (30) @(negedge clk21m);
      for (int i = 0; i < 200 && !cas_audio_out; i++) @(negedge clk21m);
      reset_n = 1'b0;
      @(negedge clk21m);
      check("midrst_audio", int'(cas_audio_out), 0);
      check("midrst_ready", int'(cmd_ready), 1);
      check("midrst_busy",  int'(busy), 0);
      reset_n = 1'b1;
      @(negedge clk21m);

      for (int k = 0; k < 16; k++) begin
         t = 2'($urandom_range(0, 3));
         d = (t == 2'b11) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
         send(t, d);
      end
      wait_idle();
      repeat (5) @(negedge clk21m);
      check("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
